// File: rtl/pwm_duty_ramp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_duty_ramp_pkg
// Brief   : Shared constants, register map and state encoding for the duty ramp.
// Revision: 1.0 - initial release
// ============================================================================
package pwm_duty_ramp_pkg;

    localparam int C_DW = 20;
    localparam int C_IW = 16;

    localparam logic [1:0] REG_PERIOD   = 2'd0;
    localparam logic [1:0] REG_TARGET   = 2'd1;
    localparam logic [1:0] REG_STEP     = 2'd2;
    localparam logic [1:0] REG_INTERVAL = 2'd3;

    localparam logic PWM_ADDR_PERIOD = 1'b0;
    localparam logic PWM_ADDR_DUTY   = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_duty_ramp_if.sv
`default_nettype none
// ============================================================================
// Module  : pwm_duty_ramp_if
// Brief   : Host write port, downstream pwm write port and ramp status.
// Revision: 1.0 - initial release
// ============================================================================
interface pwm_duty_ramp_if
    import pwm_duty_ramp_pkg::*;
#(
    parameter int DW = C_DW
);
    logic [1:0]    addr;
    logic          wr_n;
    logic [DW-1:0] i_data;
    logic          o_addr;
    logic          o_wr_n;
    logic [DW-1:0] o_data;
    logic [DW-1:0] o_duty;
    logic          o_busy;
    logic          o_done;

    modport master (
        output addr, wr_n, i_data,
        input  o_addr, o_wr_n, o_data, o_duty, o_busy, o_done
    );

    modport slave (
        input  addr, wr_n, i_data,
        output o_addr, o_wr_n, o_data, o_duty, o_busy, o_done
    );

endinterface
`default_nettype wire

// File: rtl/pwm_duty_ramp_step.sv
`default_nettype none
// ============================================================================
// Module  : pwm_duty_ramp_step
// Brief   : Next duty value one bounded step from current toward target.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_duty_ramp_step
    import pwm_duty_ramp_pkg::*;
#(
    parameter int DW = C_DW
) (
    input  wire logic [DW-1:0] i_cur,
    input  wire logic [DW-1:0] i_target,
    input  wire logic [DW-1:0] i_step,
    output logic      [DW-1:0] o_next,
    output logic               o_at_target
);
    logic          w_up;
    logic [DW-1:0] w_diff;

    always_comb begin
        w_up   = (i_target > i_cur);
        w_diff = w_up ? (i_target - i_cur) : (i_cur - i_target);
        // A zero step means "no slewing": land on target in one write.
        if ((i_step == '0) || (w_diff <= i_step)) begin
            o_next = i_target;
        end else if (w_up) begin
            o_next = i_cur + i_step;
        end else begin
            o_next = i_cur - i_step;
        end
        o_at_target = (o_next == i_target);
    end

endmodule
`default_nettype wire

// File: rtl/pwm_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module  : pwm_duty_ramp
// Brief   : Forwards period writes and slews pwm duty toward a target in steps.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_duty_ramp
    import pwm_duty_ramp_pkg::*;
#(
    parameter int DW = C_DW,
    parameter int IW = C_IW
) (
    input  wire logic      clk,
    input  wire logic      rst,
    pwm_duty_ramp_if.slave bus
);
    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_period, w_period_nxt;
    logic [DW-1:0] r_target, w_target_nxt;
    logic [DW-1:0] r_step, w_step_nxt;
    logic [DW-1:0] r_duty, w_duty_nxt;
    logic [DW-1:0] r_data, w_data_nxt;
    logic [IW-1:0] r_interval, w_interval_nxt;
    logic [IW-1:0] r_timer, w_timer_nxt;
    logic          r_addr, w_addr_nxt;
    logic          r_wr_n, w_wr_n_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;

    logic          w_per_wr, w_tgt_wr, w_step_wr, w_int_wr;
    logic [DW-1:0] w_tgt_clamp, w_tgt_on_per, w_tgt_use, w_next;
    logic          w_at_target;
    logic [IW-1:0] w_int_in, w_tick;
    logic          w_load, w_final;

    assign w_per_wr  = ~bus.wr_n && (bus.addr == REG_PERIOD);
    assign w_tgt_wr  = ~bus.wr_n && (bus.addr == REG_TARGET);
    assign w_step_wr = ~bus.wr_n && (bus.addr == REG_STEP);
    assign w_int_wr  = ~bus.wr_n && (bus.addr == REG_INTERVAL);

    assign w_tgt_clamp  = (bus.i_data > r_period) ? r_period : bus.i_data;
    assign w_tgt_on_per = (bus.i_data < r_target) ? bus.i_data : r_target;
    assign w_tgt_use    = w_tgt_wr ? w_tgt_clamp : r_target;
    assign w_int_in     = (bus.i_data[IW-1:0] == '0) ? IW'(1) : bus.i_data[IW-1:0];

    // Fed the incoming target on a TARGET write so interval 1 issues at once.
    pwm_duty_ramp_step #(
        .DW (DW)
    ) u_step (
        .i_cur       (r_duty),
        .i_target    (w_tgt_use),
        .i_step      (r_step),
        .o_next      (w_next),
        .o_at_target (w_at_target)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_period_nxt   = r_period;
        w_target_nxt   = r_target;
        w_step_nxt     = r_step;
        w_duty_nxt     = r_duty;
        w_interval_nxt = r_interval;
        w_timer_nxt    = r_timer;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_wr_n_nxt     = 1'b1;
        w_done_nxt     = 1'b0;
        w_load         = 1'b0;
        w_final        = 1'b0;
        w_tick         = r_timer;

        if (w_per_wr) begin
            w_period_nxt = bus.i_data;
            w_target_nxt = w_tgt_on_per;
            w_wr_n_nxt   = 1'b0;
            w_addr_nxt   = PWM_ADDR_PERIOD;
            w_data_nxt   = bus.i_data;
            if (bus.i_data < r_duty) begin
                w_state_nxt = ST_RAMP;
                w_load      = 1'b1;
            end
        end

        if (w_tgt_wr) begin
            w_target_nxt = w_tgt_clamp;
            if (w_tgt_clamp == r_duty) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = ST_RAMP;
                w_load      = 1'b1;
            end
        end

        if (w_step_wr) begin
            w_step_nxt = bus.i_data;
        end
        if (w_int_wr) begin
            w_interval_nxt = w_int_in;
        end

        // A (re)load counts as the first tick, so writes land interval cycles later.
        if (w_load || ((r_state == ST_RAMP) && (w_state_nxt == ST_RAMP))) begin
            w_tick = w_load ? r_interval : r_timer;
            if (w_tick <= IW'(1)) begin
                if (w_per_wr) begin
                    w_timer_nxt = IW'(1);
                end else begin
                    w_wr_n_nxt  = 1'b0;
                    w_addr_nxt  = PWM_ADDR_DUTY;
                    w_data_nxt  = w_next;
                    w_duty_nxt  = w_next;
                    w_timer_nxt = r_interval;
                    if (w_at_target) begin
                        w_final     = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end else begin
                w_timer_nxt = w_tick - IW'(1);
            end
        end

        w_busy_nxt = (w_state_nxt == ST_RAMP) || w_final;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_period   <= '0;
            r_target   <= '0;
            r_step     <= '0;
            r_duty     <= '0;
            r_interval <= IW'(1);
            r_timer    <= '0;
            r_addr     <= PWM_ADDR_PERIOD;
            r_data     <= '0;
            r_wr_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_period   <= w_period_nxt;
            r_target   <= w_target_nxt;
            r_step     <= w_step_nxt;
            r_duty     <= w_duty_nxt;
            r_interval <= w_interval_nxt;
            r_timer    <= w_timer_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_wr_n     <= w_wr_n_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign bus.o_addr = r_addr;
    assign bus.o_wr_n = r_wr_n;
    assign bus.o_data = r_data;
    assign bus.o_duty = r_duty;
    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_duty_ramp
// Brief   : Directed self-checking bench for the pwm duty ramp sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pwm_duty_ramp;
    import pwm_duty_ramp_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pwm_duty_ramp_if #(.DW(20)) bus ();

    pwm_duty_ramp #(
        .DW (20),
        .IW (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic host_write(input logic [1:0] a, input logic [19:0] d);
        bus.addr   = a;
        bus.i_data = d;
        bus.wr_n   = 1'b0;
        @(negedge clk);
        bus.wr_n   = 1'b1;
    endtask

    // Advance n cycles; no write may appear before the n-th, which must carry v.
    task automatic run_to_write(input int n, input logic [19:0] v, input logic d, input string tag);
        int stray;
        stray = 0;
        for (int i = 1; i < n; i++) begin
            tick();
            if (bus.o_wr_n !== 1'b1) stray++;
        end
        tick();
        check({tag, " gap"}, 32'(stray), 32'd0);
        check({tag, " wr_n"}, {31'd0, bus.o_wr_n}, 32'd0);
        check({tag, " addr"}, {31'd0, bus.o_addr}, 32'd1);
        check({tag, " data"}, {12'd0, bus.o_data}, {12'd0, v});
        check({tag, " duty"}, {12'd0, bus.o_duty}, {12'd0, v});
        check({tag, " done"}, {31'd0, bus.o_done}, {31'd0, d});
    endtask

    initial begin
        int stray;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.addr   = 2'd0;
        bus.wr_n   = 1'b1;
        bus.i_data = '0;
        repeat (3) tick();
        check("rst wr_n", {31'd0, bus.o_wr_n}, 32'd1);
        check("rst addr", {31'd0, bus.o_addr}, 32'd0);
        check("rst data", {12'd0, bus.o_data}, 32'd0);
        check("rst duty", {12'd0, bus.o_duty}, 32'd0);
        check("rst busy", {31'd0, bus.o_busy}, 32'd0);
        check("rst done", {31'd0, bus.o_done}, 32'd0);
        rst = 1'b0;
        tick();

        // Ramp up 0 -> 400, step 100, interval 10
        host_write(REG_INTERVAL, 20'd10);
        host_write(REG_STEP, 20'd100);
        host_write(REG_PERIOD, 20'd1000);
        check("per wr_n", {31'd0, bus.o_wr_n}, 32'd0);
        check("per addr", {31'd0, bus.o_addr}, 32'd0);
        check("per data", {12'd0, bus.o_data}, 32'd1000);
        tick();
        check("per one cycle", {31'd0, bus.o_wr_n}, 32'd1);
        host_write(REG_TARGET, 20'd400);
        check("up busy", {31'd0, bus.o_busy}, 32'd1);
        check("up no wr", {31'd0, bus.o_wr_n}, 32'd1);
        run_to_write(9, 20'd100, 1'b0, "up100");
        run_to_write(10, 20'd200, 1'b0, "up200");
        run_to_write(10, 20'd300, 1'b0, "up300");
        run_to_write(10, 20'd400, 1'b1, "up400");
        check("up busy at last", {31'd0, bus.o_busy}, 32'd1);
        tick();
        check("up busy drop", {31'd0, bus.o_busy}, 32'd0);
        check("up done pulse", {31'd0, bus.o_done}, 32'd0);

        // Ramp down 400 -> 0, step 150
        host_write(REG_STEP, 20'd150);
        host_write(REG_TARGET, 20'd0);
        check("dn busy", {31'd0, bus.o_busy}, 32'd1);
        run_to_write(9, 20'd250, 1'b0, "dn250");
        run_to_write(10, 20'd100, 1'b0, "dn100");
        run_to_write(10, 20'd0, 1'b1, "dn0");
        tick();
        check("dn busy drop", {31'd0, bus.o_busy}, 32'd0);

        // Clamp to period, step 0 jumps in one write
        host_write(REG_STEP, 20'd0);
        host_write(REG_TARGET, 20'd2000);
        check("clamp busy", {31'd0, bus.o_busy}, 32'd1);
        run_to_write(9, 20'd1000, 1'b1, "clamp");
        tick();
        check("clamp busy drop", {31'd0, bus.o_busy}, 32'd0);

        // Period write on the duty-write cycle: duty slips one cycle
        host_write(REG_STEP, 20'd100);
        host_write(REG_TARGET, 20'd300);
        repeat (8) tick();
        host_write(REG_PERIOD, 20'd1000);
        check("coll per wr_n", {31'd0, bus.o_wr_n}, 32'd0);
        check("coll per addr", {31'd0, bus.o_addr}, 32'd0);
        check("coll per data", {12'd0, bus.o_data}, 32'd1000);
        run_to_write(1, 20'd900, 1'b0, "coll900");
        for (int v = 800; v >= 300; v -= 100) begin
            run_to_write(10, 20'(v), (v == 300), "coll");
        end

        // Retarget 800 -> 200 mid-ramp at 500
        host_write(REG_TARGET, 20'd800);
        run_to_write(9, 20'd400, 1'b0, "rt400");
        run_to_write(10, 20'd500, 1'b0, "rt500");
        repeat (4) tick();
        host_write(REG_TARGET, 20'd200);
        check("rt no wr", {31'd0, bus.o_wr_n}, 32'd1);
        check("rt busy", {31'd0, bus.o_busy}, 32'd1);
        run_to_write(9, 20'd400, 1'b0, "rtd400");
        run_to_write(10, 20'd300, 1'b0, "rtd300");
        run_to_write(10, 20'd200, 1'b1, "rtd200");
        tick();
        check("rt busy drop", {31'd0, bus.o_busy}, 32'd0);

        // Target equal to current duty
        host_write(REG_TARGET, 20'd200);
        check("eq done", {31'd0, bus.o_done}, 32'd1);
        check("eq busy", {31'd0, bus.o_busy}, 32'd0);
        check("eq no wr", {31'd0, bus.o_wr_n}, 32'd1);
        tick();
        check("eq done pulse", {31'd0, bus.o_done}, 32'd0);

        // Reset lands on a due duty-write edge
        host_write(REG_TARGET, 20'd600);
        run_to_write(9, 20'd300, 1'b0, "pre rst");
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("mid rst wr_n", {31'd0, bus.o_wr_n}, 32'd1);
        check("mid rst duty", {12'd0, bus.o_duty}, 32'd0);
        check("mid rst busy", {31'd0, bus.o_busy}, 32'd0);
        check("mid rst done", {31'd0, bus.o_done}, 32'd0);
        rst   = 1'b0;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if ((bus.o_wr_n !== 1'b1) || (bus.o_busy !== 1'b0)) stray++;
        end
        check("post rst quiet", 32'(stray), 32'd0);

        // Interval 0 stored as 1: one write per cycle, first in N+1
        host_write(REG_PERIOD, 20'd1000);
        check("per2 data", {12'd0, bus.o_data}, 32'd1000);
        host_write(REG_INTERVAL, 20'd0);
        host_write(REG_STEP, 20'd250);
        host_write(REG_TARGET, 20'd1000);
        check("i1 wr_n", {31'd0, bus.o_wr_n}, 32'd0);
        check("i1 addr", {31'd0, bus.o_addr}, 32'd1);
        check("i1 data", {12'd0, bus.o_data}, 32'd250);
        check("i1 busy", {31'd0, bus.o_busy}, 32'd1);
        run_to_write(1, 20'd500, 1'b0, "i1 500");
        run_to_write(1, 20'd750, 1'b0, "i1 750");
        run_to_write(1, 20'd1000, 1'b1, "i1 1000");
        tick();
        check("i1 busy drop", {31'd0, bus.o_busy}, 32'd0);

        // Period below current duty retargets downward, period forwarded first
        host_write(REG_PERIOD, 20'd300);
        check("pdn wr_n", {31'd0, bus.o_wr_n}, 32'd0);
        check("pdn addr", {31'd0, bus.o_addr}, 32'd0);
        check("pdn data", {12'd0, bus.o_data}, 32'd300);
        check("pdn busy", {31'd0, bus.o_busy}, 32'd1);
        run_to_write(1, 20'd750, 1'b0, "pdn750");
        run_to_write(1, 20'd500, 1'b0, "pdn500");
        run_to_write(1, 20'd300, 1'b1, "pdn300");
        tick();
        check("pdn busy drop", {31'd0, bus.o_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
